// File: rtl/pulse_gen_pkg.sv
// Shared types and helpers for the pulse train generator.
// Holds the FSM state encoding, the default field width and the zero-length fixup.
package pulse_gen_pkg;

  localparam int unsigned DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  // A zero length would give a zero-width phase, so it is treated as one cycle.
  function automatic logic [31:0] nz_len(input logic [31:0] len);
    return (len == 32'd0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/pulse_phase_timer.sv
// Loadable down-counter that times the HIGH and LOW phases.
// The counter holds at zero, so a phase loaded with len-1 lasts exactly len cycles.
import pulse_gen_pkg::*;

module pulse_phase_timer #(
  parameter int unsigned W = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                r_cnt <= '0;
    else if (load)           r_cnt <= load_val;
    else if (r_cnt != '0)    r_cnt <= r_cnt - W'(1);
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_gen.sv
// Pulse train generator: N pulses of H high cycles separated by L low cycles.
// All outputs come straight from flops, so every edge lands on a clock boundary.
//
//   state | meaning
//   IDLE  | waiting for start, out=0 busy=0
//   HIGH  | high phase of a pulse, out=1 busy=1
//   LOW   | gap between pulses, out=0 busy=1
import pulse_gen_pkg::*;

module pulse_train_gen #(
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_pulses,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next_state;
  logic             r_out;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_pulses;
  logic [CNT_W-1:0] r_hl_m1;
  logic [CNT_W-1:0] r_ll_m1;

  logic [CNT_W-1:0] w_next_pulses;
  logic             w_next_done;
  logic             w_accept;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_zero;
  logic [CNT_W-1:0] w_hl_m1_in;
  logic [CNT_W-1:0] w_ll_m1_in;

  // Lengths are stored already decremented, ready to load into the timer.
  assign w_hl_m1_in = CNT_W'(nz_len(32'(high_len))) - CNT_W'(1);
  assign w_ll_m1_in = CNT_W'(nz_len(32'(low_len))) - CNT_W'(1);

  pulse_phase_timer #(.W(CNT_W)) u_phase_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .load_val (w_load_val),
    .zero     (w_zero)
  );

  always_comb begin
    w_next_state  = r_state;
    w_next_pulses = r_pulses;
    w_next_done   = 1'b0;
    w_accept      = 1'b0;
    w_load        = 1'b0;
    w_load_val    = r_hl_m1;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          if (num_pulses == '0) begin
            w_next_done = 1'b1;
          end else begin
            w_next_state  = HIGH;
            w_load        = 1'b1;
            w_load_val    = w_hl_m1_in;
            w_next_pulses = num_pulses;
          end
        end
      end
      HIGH: begin
        if (w_zero) begin
          w_next_pulses = r_pulses - CNT_W'(1);
          if (r_pulses == CNT_W'(1)) begin
            w_next_state = IDLE;
            w_next_done  = 1'b1;
          end else begin
            w_next_state = LOW;
            w_load       = 1'b1;
            w_load_val   = r_ll_m1;
          end
        end
      end
      LOW: begin
        if (w_zero) begin
          w_next_state = HIGH;
          w_load       = 1'b1;
          w_load_val   = r_hl_m1;
        end
      end
      default: w_next_state = IDLE;
    endcase
    // Abort wins over accept and over a completing train.
    if (abort) begin
      w_next_state = IDLE;
      w_next_done  = 1'b0;
      w_accept     = 1'b0;
      w_load       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_out    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_pulses <= '0;
      r_hl_m1  <= '0;
      r_ll_m1  <= '0;
    end else begin
      r_state  <= w_next_state;
      r_out    <= (w_next_state == HIGH);
      r_busy   <= (w_next_state != IDLE);
      r_done   <= w_next_done;
      r_pulses <= w_next_pulses;
      if (w_accept) begin
        r_hl_m1 <= w_hl_m1_in;
        r_ll_m1 <= w_ll_m1_in;
      end
    end
  end

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench for pulse_train_gen: a per-cycle model of {out,busy,done}
// is queued when a train is launched and compared cycle by cycle.
module tb_pulse_train_gen;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] num_pulses;
  logic [W-1:0] high_len;
  logic [W-1:0] low_len;
  logic         abort;
  logic         out;
  logic         busy;
  logic         done;

  int passed = 0;
  int total  = 0;
  logic [2:0] sb[$];
  logic [2:0] exp_v;

  pulse_train_gen #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_pulses (num_pulses),
    .high_len   (high_len),
    .low_len    (low_len),
    .abort      (abort),
    .out        (out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected {out,busy,done} per cycle, starting with the cycle after accept.
  function automatic void push_train(int n, int h, int l, bit idle_tail);
    int hh = (h == 0) ? 1 : h;
    int ll = (l == 0) ? 1 : l;
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < hh; c++) sb.push_back(3'b110);
      if (p < n - 1)
        for (int c = 0; c < ll; c++) sb.push_back(3'b010);
    end
    sb.push_back(3'b001);
    if (idle_tail) sb.push_back(3'b000);
  endfunction

  task automatic set_fields(int n, int h, int l);
    start      = 1'b1;
    num_pulses = W'(n);
    high_len   = W'(h);
    low_len    = W'(l);
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    num_pulses = '0; high_len = '0; low_len = '0;
    #23;
    total++;
    if ({out, busy, done} !== 3'b000)
      $display("FAIL reset: got %b expected 000", {out, busy, done});
    else passed++;
    rst = 1'b1;
    step();
    step();
    total++;
    if ({out, busy, done} !== 3'b000)
      $display("FAIL reset_idle: got %b expected 000", {out, busy, done});
    else passed++;
  endtask

  task automatic test_basic(string name, int n, int h, int l);
    set_fields(n, h, l);
    push_train(n, h, l, 1'b1);
    while (sb.size() > 0) begin
      step();
      start = 1'b0;
      num_pulses = W'($urandom);
      exp_v = sb.pop_front();
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL %s: got %b expected %b", name, {out, busy, done}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    bit relaunched = 1'b0;
    set_fields(1, 1, 4);
    push_train(1, 1, 4, 1'b0);
    while (sb.size() > 0) begin
      step();
      start = 1'b0;
      exp_v = sb.pop_front();
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL back_to_back: got %b expected %b", {out, busy, done}, exp_v);
      else passed++;
      if (exp_v[0] && !relaunched) begin
        relaunched = 1'b1;
        set_fields(1, 1, 0);
        push_train(1, 1, 0, 1'b1);
      end
    end
  endtask

  task automatic test_ignore_busy();
    set_fields(2, 3, 2);
    push_train(2, 3, 2, 1'b1);
    while (sb.size() > 0) begin
      step();
      exp_v = sb.pop_front();
      // Keep hammering start with other fields for as long as the train runs.
      start      = exp_v[1];
      num_pulses = W'(7);
      high_len   = W'(9);
      low_len    = W'(5);
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL ignore_busy: got %b expected %b", {out, busy, done}, exp_v);
      else passed++;
    end
    start = 1'b0;
  endtask

  task automatic test_abort();
    int idx = 0;
    set_fields(4, 3, 2);
    push_train(4, 3, 2, 1'b0);
    while (sb.size() > 7) void'(sb.pop_back());
    for (int i = 0; i < 3; i++) sb.push_back(3'b000);
    while (sb.size() > 0) begin
      step();
      start = 1'b0;
      abort = (idx == 6);
      exp_v = sb.pop_front();
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL abort: got %b expected %b", {out, busy, done}, exp_v);
      else passed++;
      idx++;
    end
    set_fields(1, 1, 1);
    abort = 1'b1;
    sb.push_back(3'b000);
    sb.push_back(3'b000);
    while (sb.size() > 0) begin
      step();
      start = 1'b0;
      abort = 1'b0;
      exp_v = sb.pop_front();
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL abort_start: got %b expected %b", {out, busy, done}, exp_v);
      else passed++;
    end
  endtask

  task automatic test_rst_mid();
    set_fields(3, 4, 2);
    push_train(3, 4, 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      start = 1'b0;
      exp_v = sb.pop_front();
      total++;
      if ({out, busy, done} !== exp_v)
        $display("FAIL rst_pre: got %b expected %b", {out, busy, done}, exp_v);
      else passed++;
    end
    sb.delete();
    #2 rst = 1'b0;
    #1;
    total++;
    if ({out, busy, done} !== 3'b000)
      $display("FAIL rst_async: got %b expected 000", {out, busy, done});
    else passed++;
    step();
    #2 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if ({out, busy, done} !== 3'b000)
        $display("FAIL rst_release_idle: got %b expected 000", {out, busy, done});
      else passed++;
    end
    test_basic("rst_new_train", 1, 5, 3);
  endtask

  initial begin
    test_reset();
    test_basic("basic_n3_h2_l1", 3, 2, 1);
    test_basic("zero_pulses", 0, 3, 3);
    test_basic("zero_lengths", 2, 0, 0);
    test_basic("n2_h255_l3", 2, 255, 3);
    test_back_to_back();
    test_ignore_busy();
    test_abort();
    test_rst_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
# pulse_train_gen

Registered edge/pulse generator: on a start command it emits a train of `num_pulses` pulses on `out`, each high for `high_len` cycles and separated by `low_len` low cycles. It is the transmit-side counterpart of the team's edge detector. It drives test strobes, handshake pulses and stimulus lines whose rising and falling edges are consumed downstream by edge detectors. Every edge it produces is at least one full clock cycle apart, so a synchronous detector sees every edge.

## Interface
Parameters:
- `CNT_W`, default 8: width of the count, high-length and low-length fields.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  command strobe. Sampled only while `busy`=0.
- `num_pulses`  in  CNT_W  number of pulses in the train. Latched on accepted `start`.
- `high_len`  in  CNT_W  high-phase length in cycles. Latched on accepted `start`; 0 is treated as 1.
- `low_len`  in  CNT_W  gap length in cycles. Latched on accepted `start`; 0 is treated as 1.
- `abort`  in  1  terminates any train; takes effect at the next edge.
- `out`  out  1  generated waveform, driven directly from a flop.
- `busy`  out  1  high from the cycle after accept until the train ends or is aborted.
- `done`  out  1  one-cycle pulse on normal completion only.

## Operation
- States:
  - IDLE: `out`=0, `busy`=0.
  - HIGH: `out`=1, `busy`=1.
  - LOW: `out`=0, `busy`=1.
- Reset (async, `rst`=0):
  - state = IDLE; `out`, `busy`, `done` = 0.
  - Internal counters are cleared.
- Accept: in IDLE with `start`=1 and `abort`=0.
  - Latch all three fields, with 0 mapped to 1 for the two lengths.
  - If `num_pulses`=0: stay in IDLE, pulse `done` next cycle, no activity on `out`.
  - Otherwise: go to HIGH, load the phase counter with `high_len`-1, load the pulse counter with `num_pulses`.
- HIGH: the phase counter decrements each cycle. When it is 0:
  - Decrement the pulse counter.
  - If it was 1, go to IDLE and assert `done` for one cycle.
  - Otherwise go to LOW and load `low_len`-1.
- LOW: the phase counter decrements. When it is 0, go to HIGH and load `high_len`-1.
- `abort`:
  - In any state, go to IDLE at the next edge: `out`=0, `busy`=0, `done` stays 0.
  - `abort` overrides a simultaneous `start`, and a simultaneous completion (no `done`).
- `start` while `busy`=1 is ignored, with no queueing. Input fields are don't-care except on the accept cycle.
- Back-to-back trains: `start` may be accepted in the cycle `done`=1. This gives exactly one low cycle between trains.
- Counter arithmetic: unsigned CNT_W, no wrap. A maximum field value of 2^CNT_W-1 produces exactly that many cycles or pulses.

## Timing
- Accept at edge k: `out`=1 and `busy`=1 from edge k+1.
- Each pulse: `out` high for exactly H = max(`high_len`,1) cycles.
- Each gap between pulses: `out` low for exactly L = max(`low_len`,1) cycles.
- Total busy cycles = N·H + (N−1)·L.
- At the end: `out`=0, `busy`=0 and `done`=1 in the same cycle, immediately after the last high cycle.
- `num_pulses`=0 accepted at edge k: `done`=1 during cycle k+1; `busy` never rises.
- Reset asserted mid-train: outputs go to 0 immediately (asynchronously), with no `done`. On release, the block waits in IDLE for a new `start`.

## Structure
- Shared package `pulse_gen_pkg`:
  - state enum {IDLE, HIGH, LOW};
  - default `CNT_W`;
  - a function mapping a zero length to 1.
- One sub-module, `pulse_phase_timer`:
  - a CNT_W loadable down-counter with `load`, `load_val` and `zero` outputs;
  - the FSM instantiates it for phase timing;
  - the pulse counter stays inline.

## Test plan
- Reset, then `start` with N=3, H=2, L=1 → `out` = 1,1,0,1,1,0,1,1 from the cycle after accept. `busy`=1 for 8 cycles. `done`=1 in the 9th cycle.
- N=0 → `done` one cycle after accept; `out` and `busy` stay 0.
- N=2, `high_len`=0, `low_len`=0 → `out` = 1,0,1, then `done`.
- `start` re-asserted in the `done` cycle with N=1, H=1 → exactly one low cycle between trains. `start` pulses while `busy`=1 are ignored.
- `abort` during the second HIGH of N=4, H=3, L=2 → `out`=0 and `busy`=0 next cycle, `done` never asserted. `abort`+`start` together in IDLE → no accept.
- `rst` low mid-train → outputs 0 asynchronously. After release, a new train with N=1, H=5 runs normally.
